// File: rtl/pipeline_stage_regs_if.sv
// Stage-register bank port bundle: fetch handshake, hazard-control commands, hazard feedback and WB port.
// slave = pipeline_stage_regs side, master = hazard unit / fetch / writeback environment side.
interface pipeline_stage_regs_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              if_valid;
    logic [DATA_W-1:0] if_data;
    logic              if_ready;
    logic [4:0]        rd_dec;
    logic              rd_used_dec;
    logic [DATA_W-1:0] dec_data;
    logic              dec_valid;
    logic              fetch_halt, dec_halt, op_halt, ex_halt, mem_halt, wb_halt;
    logic              fetch_nop, dec_nop, op_nop, ex_nop, mem_nop, wb_nop;
    logic              flush;
    logic [4:0]        rd_op;
    logic              rd_used_op;
    logic [4:0]        rd_ex;
    logic              rd_used_ex;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic              wb_rd_used;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              proto_err;

    modport slave (
        input  if_valid, if_data, rd_dec, rd_used_dec,
        input  fetch_halt, dec_halt, op_halt, ex_halt, mem_halt, wb_halt,
        input  fetch_nop, dec_nop, op_nop, ex_nop, mem_nop, wb_nop, flush,
        output if_ready, dec_data, dec_valid, rd_op, rd_used_op, rd_ex, rd_used_ex,
        output wb_valid, wb_rd, wb_rd_used, wb_data, stall_cnt, bubble_cnt, proto_err
    );

    modport master (
        output if_valid, if_data, rd_dec, rd_used_dec,
        output fetch_halt, dec_halt, op_halt, ex_halt, mem_halt, wb_halt,
        output fetch_nop, dec_nop, op_nop, ex_nop, mem_nop, wb_nop, flush,
        input  if_ready, dec_data, dec_valid, rd_op, rd_used_op, rd_ex, rd_used_ex,
        input  wb_valid, wb_rd, wb_rd_used, wb_data, stall_cnt, bubble_cnt, proto_err
    );
endinterface

// File: rtl/pipeline_stage_regs.sv
// DEC/OP/EX/MEM/WB stage registers driven by hazard-unit halt/nop/flush; optional PIPE_PERF_CNT_EN perf counters.
// Latency: fetch->DEC 1 edge, ->WB 5 edges with no halts; all outputs registered except if_ready.
// Backpressure: if_ready = !fetch_halt; a halted stage holds and the stage after it loads a bubble.
module pipeline_stage_regs #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    pipeline_stage_regs_if.slave pif
);
    typedef struct packed {
        logic              valid;
        logic [4:0]        rd;
        logic              rd_used;
        logic [DATA_W-1:0] data;
    } stage_t;

    // DEC carries only valid/data; index 2..5 = OP, EX, MEM, WB.
    logic              dec_valid_q, dec_valid_d;
    logic [DATA_W-1:0] dec_data_q, dec_data_d;
    stage_t            stg_q   [2:5];
    stage_t            stg_d   [2:5];
    stage_t            stg_src [2:5];
    logic              proto_err_q, proto_err_d;
    logic [5:0]        halt, nop, next_halt;

    assign halt      = {pif.wb_halt, pif.mem_halt, pif.ex_halt, pif.op_halt, pif.dec_halt, pif.fetch_halt};
    assign nop       = {pif.wb_nop, pif.mem_nop, pif.ex_nop, pif.op_nop, pif.dec_nop, pif.fetch_nop};
    assign next_halt = {1'b0, halt[5:1]};

    always_comb begin
        dec_valid_d = dec_valid_q;
        dec_data_d  = dec_data_q;
        if (pif.flush) begin
            dec_valid_d = 1'b0;
            dec_data_d  = '0;
        end else if (!pif.dec_halt) begin
            if (pif.fetch_halt || pif.fetch_nop) begin
                dec_valid_d = 1'b0;
                dec_data_d  = '0;
            end else begin
                dec_valid_d = pif.if_valid;
                dec_data_d  = pif.if_data;
            end
        end
    end

    // OP samples the decoder's destination; x0 and bubbles never report a live rd.
    always_comb begin
        stg_src[2].valid   = dec_valid_q;
        stg_src[2].rd      = pif.rd_dec;
        stg_src[2].rd_used = pif.rd_used_dec & dec_valid_q & (pif.rd_dec != 5'd0);
        stg_src[2].data    = dec_data_q;
        for (int k = 3; k <= 5; k++) begin
            stg_src[k] = stg_q[k-1];
        end
    end

    always_comb begin
        for (int k = 2; k <= 5; k++) begin
            stg_d[k] = stg_q[k];
            if (pif.flush && (k <= 3)) begin
                stg_d[k] = '0;
            end else if (!halt[k]) begin
                if (halt[k-1] || nop[k-1]) begin
                    stg_d[k] = '0;
                end else begin
                    stg_d[k] = stg_src[k];
                end
            end
        end
    end

    always_comb begin
        proto_err_d = proto_err_q;
        for (int i = 0; i < 6; i++) begin
            if ((halt[i] && !next_halt[i] && !nop[i]) || (nop[i] && !halt[i])) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_q <= 1'b0;
            dec_data_q  <= '0;
            proto_err_q <= 1'b0;
            for (int k = 2; k <= 5; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            dec_valid_q <= dec_valid_d;
            dec_data_q  <= dec_data_d;
            proto_err_q <= proto_err_d;
            for (int k = 2; k <= 5; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             bubble_evt;

    // Only OP/EX bubbles coming from a halt/nop upstream count; flush squashes do not.
    assign bubble_evt = !pif.flush &&
                        ((!pif.op_halt && (pif.dec_halt || pif.dec_nop)) ||
                         (!pif.ex_halt && (pif.op_halt || pif.op_nop)));

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (pif.fetch_halt && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (bubble_evt && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign pif.stall_cnt  = stall_cnt_q;
    assign pif.bubble_cnt = bubble_cnt_q;
`else
    assign pif.stall_cnt  = '0;
    assign pif.bubble_cnt = '0;
`endif

    assign pif.if_ready   = !pif.fetch_halt;
    assign pif.dec_valid  = dec_valid_q;
    assign pif.dec_data   = dec_data_q;
    assign pif.rd_op      = stg_q[2].rd;
    assign pif.rd_used_op = stg_q[2].rd_used;
    assign pif.rd_ex      = stg_q[3].rd;
    assign pif.rd_used_ex = stg_q[3].rd_used;
    assign pif.wb_valid   = stg_q[5].valid;
    assign pif.wb_rd      = stg_q[5].rd;
    assign pif.wb_rd_used = stg_q[5].rd_used;
    assign pif.wb_data    = stg_q[5].data;
    assign pif.proto_err  = proto_err_q;
endmodule
